// File: rtl/mem_bus_ctrl.sv
// Memory-bus controller between the CPU datapath and a synchronous data RAM.
// Hides the RAM's one-cycle registered read latency behind a req/ack handshake
// and decodes two memory-mapped I/O words: an LED register (write-only) and a
// switch port (read-only).
module mem_bus_ctrl #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 9,
    parameter logic [ADDR_WIDTH-1:0] LED_ADDR   = 9'h1FF,
    parameter logic [ADDR_WIDTH-1:0] SW_ADDR    = 9'h1FE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rd_req,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  ack,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_read_address,
    output logic [ADDR_WIDTH-1:0] ram_write_address,
    output logic                  ram_write,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    input  logic [DATA_WIDTH-1:0] switches,
    output logic [DATA_WIDTH-1:0] leds
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_RD_ISSUE   = 2'd1,
        S_RD_CAPTURE = 2'd2,
        S_WR_COMMIT  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [DATA_WIDTH-1:0] r_wdata_q;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_leds;
    logic                  w_idle;
    logic                  w_hit_led;
    logic                  w_hit_sw;
    logic                  w_ram_write;
    logic                  w_busy;

    assign w_idle    = (r_state == S_IDLE);
    assign w_hit_led = (cpu_addr == LED_ADDR);
    assign w_hit_sw  = (cpu_addr == SW_ADDR);

    // State register: the only place the FSM state is updated.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: writes win over reads; I/O hits complete without leaving IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (wr_req) begin
                    if (w_hit_led) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_state = S_WR_COMMIT;
                    end
                end else if (rd_req) begin
                    if (w_hit_sw) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_state = S_RD_ISSUE;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_RD_ISSUE:   w_next_state = S_RD_CAPTURE;
            S_RD_CAPTURE: w_next_state = S_IDLE;
            S_WR_COMMIT:  w_next_state = S_IDLE;
            default:      w_next_state = S_IDLE;
        endcase
    end

    // Output decode: RAM strobe and busy come from the state register only.
    always_comb begin
        w_ram_write = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE:       w_busy = 1'b0;
            S_WR_COMMIT:  w_ram_write = 1'b1;
            S_RD_ISSUE,
            S_RD_CAPTURE: w_ram_write = 1'b0;
            default: begin
                w_ram_write = 1'b0;
                w_busy      = 1'b0;
            end
        endcase
    end

    // Datapath registers: request capture, read data, LED register and ack pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr_q    <= {ADDR_WIDTH{1'b0}};
            r_wdata_q   <= {DATA_WIDTH{1'b0}};
            r_cpu_rdata <= {DATA_WIDTH{1'b0}};
            r_ack       <= 1'b0;
            r_leds      <= {DATA_WIDTH{1'b0}};
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wr_req || rd_req) begin
                        r_addr_q  <= cpu_addr;
                        r_wdata_q <= cpu_wdata;
                    end
                    if (wr_req) begin
                        if (w_hit_led) begin
                            r_leds <= cpu_wdata;
                            r_ack  <= 1'b1;
                        end
                    end else if (rd_req && w_hit_sw) begin
                        r_cpu_rdata <= switches;
                        r_ack       <= 1'b1;
                    end
                end
                S_RD_CAPTURE: begin
                    r_cpu_rdata <= ram_dout;
                    r_ack       <= 1'b1;
                end
                S_WR_COMMIT: begin
                    r_ack <= 1'b1;
                end
                default: begin
                    r_ack <= 1'b0;
                end
            endcase
        end
    end

    assign ram_read_address  = r_addr_q;
    assign ram_write_address = r_addr_q;
    assign ram_din           = r_wdata_q;
    assign ram_write         = w_ram_write;
    assign busy              = w_busy;
    assign cpu_rdata         = r_cpu_rdata;
    assign ack               = r_ack;
    assign leds              = r_leds;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed vector table, hand-written
// multi-cycle sequences, and randomized requests against a transaction-level model.
module tb_mem_bus_ctrl;

    localparam logic [8:0] LED_A = 9'h1FF;
    localparam logic [8:0] SW_A  = 9'h1FE;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rd_req = 1'b0;
    logic        wr_req = 1'b0;
    logic [8:0]  cpu_addr = 9'h000;
    logic [15:0] cpu_wdata = 16'h0000;
    logic [15:0] cpu_rdata;
    logic        ack;
    logic        busy;
    logic [8:0]  ram_read_address;
    logic [8:0]  ram_write_address;
    logic        ram_write;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic [15:0] switches = 16'h0000;
    logic [15:0] leds;

    int total = 0;
    int bad   = 0;

    // Environment RAM (synchronous, registered read)
    logic [15:0] ram [0:511];

    // Reference model state: memory contents and architecturally visible registers
    logic [15:0] m_mem [0:511];
    logic [15:0] m_rdata = 16'h0000;
    logic [15:0] m_leds  = 16'h0000;

    mem_bus_ctrl dut (
        .clk(clk), .reset_n(reset_n), .rd_req(rd_req), .wr_req(wr_req),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .ack(ack), .busy(busy), .ram_read_address(ram_read_address),
        .ram_write_address(ram_write_address), .ram_write(ram_write),
        .ram_din(ram_din), .ram_dout(ram_dout), .switches(switches), .leds(leds)
    );

    always #5 clk = ~clk;

    // Synchronous RAM behaviour
    always @(posedge clk) begin
        if (ram_write) ram[ram_write_address] <= ram_din;
        ram_dout <= ram[ram_read_address];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transaction-level model: latency in cycles, RAM write strobes, new visible state
    task automatic model_apply(input logic rd, input logic wr, input logic [8:0] a,
                               input logic [15:0] d, input logic [15:0] sw,
                               output int lat, output int wcnt);
        lat = 0; wcnt = 0;
        if (wr) begin
            if (a == LED_A) begin m_leds = d; lat = 1; end
            else begin m_mem[a] = d; lat = 2; wcnt = 1; end
        end else if (rd) begin
            if (a == SW_A) begin m_rdata = sw; lat = 1; end
            else begin m_rdata = m_mem[a]; lat = 3; end
        end
    endtask

    task automatic run_req(input string nm, input logic rd, input logic wr,
                           input logic [8:0] a, input logic [15:0] d, input logic [15:0] sw,
                           input int lat, input int wcnt,
                           input logic [15:0] ex_rdata, input logic [15:0] ex_leds);
        int got, nbusy, nwr;
        got = 0; nbusy = 0; nwr = 0;
        @(negedge clk);
        rd_req = rd; wr_req = wr; cpu_addr = a; cpu_wdata = d; switches = sw;
        @(posedge clk);
        #1;
        rd_req = 1'b0; wr_req = 1'b0;
        for (int c = 1; c <= 6 && got == 0; c++) begin
            @(negedge clk);
            if (ram_write) begin
                nwr++;
                chk({nm, " waddr"}, 32'(ram_write_address), 32'(a));
                chk({nm, " din"}, 32'(ram_din), 32'(d));
            end
            if (ack) begin
                got = c;
                chk({nm, " busy_at_ack"}, 32'(busy), 32'd0);
            end else if (busy) begin
                nbusy++;
            end
        end
        chk({nm, " latency"}, 32'(got), 32'(lat));
        chk({nm, " busy_cycles"}, 32'(nbusy), 32'(lat - 1));
        chk({nm, " ram_write_cycles"}, 32'(nwr), 32'(wcnt));
        chk({nm, " rdata"}, 32'(cpu_rdata), 32'(ex_rdata));
        chk({nm, " leds"}, 32'(leds), 32'(ex_leds));
        @(negedge clk);
        chk({nm, " ack_one_cycle"}, 32'(ack), 32'd0);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [8:0]  addr;
        logic [15:0] wdata;
        logic [15:0] sw;
        int          lat;
        int          wcnt;
        logic [15:0] rdata;
        logic [15:0] leds;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int lat, wcnt, nack;
        logic [4:0] pat;
        logic rd, wr;
        logic [8:0] a;
        logic [15:0] d, sw;

        for (int i = 0; i < 512; i++) begin
            ram[i]   = 16'h0000;
            m_mem[i] = 16'h0000;
        end

        //           rd    wr    addr    wdata     sw        lat wcnt rdata     leds
        tbl[0] = '{1'b0, 1'b1, 9'h005, 16'hABCD, 16'h0000, 2, 1, 16'h0000, 16'h0000};
        tbl[1] = '{1'b1, 1'b0, 9'h005, 16'h0000, 16'h0000, 3, 0, 16'hABCD, 16'h0000};
        tbl[2] = '{1'b0, 1'b1, 9'h1FF, 16'h00F0, 16'h0000, 1, 0, 16'hABCD, 16'h00F0};
        tbl[3] = '{1'b1, 1'b0, 9'h1FE, 16'h0000, 16'h1234, 1, 0, 16'h1234, 16'h00F0};
        tbl[4] = '{1'b1, 1'b1, 9'h00A, 16'h5555, 16'h0000, 2, 1, 16'h1234, 16'h00F0};
        tbl[5] = '{1'b1, 1'b0, 9'h00A, 16'h0000, 16'h0000, 3, 0, 16'h5555, 16'h00F0};
        tbl[6] = '{1'b0, 1'b1, 9'h1FE, 16'h7777, 16'h0000, 2, 1, 16'h5555, 16'h00F0};
        tbl[7] = '{1'b1, 1'b0, 9'h1FF, 16'h0000, 16'h0000, 3, 0, 16'h0000, 16'h00F0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst ack", 32'(ack), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst ram_write", 32'(ram_write), 32'd0);
        chk("rst rdata", 32'(cpu_rdata), 32'd0);
        chk("rst leds", 32'(leds), 32'd0);
        chk("rst addr", 32'(ram_read_address), 32'd0);
        chk("rst din", 32'(ram_din), 32'd0);
        reset_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            model_apply(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].sw, lat, wcnt);
            run_req($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                    tbl[i].sw, tbl[i].lat, tbl[i].wcnt, tbl[i].rdata, tbl[i].leds);
        end

        // Read pulsed during WR_COMMIT is ignored: exactly one ack
        nack = 0;
        @(negedge clk);
        wr_req = 1'b1; cpu_addr = 9'h010; cpu_wdata = 16'h2222;
        @(posedge clk);
        #1;
        wr_req = 1'b0; rd_req = 1'b1;
        @(negedge clk);
        if (ack) nack++;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ack) nack++;
        end
        m_mem[9'h010] = 16'h2222;
        chk("ignore ack_count", 32'(nack), 32'd1);
        chk("ignore busy", 32'(busy), 32'd0);
        chk("ignore rdata", 32'(cpu_rdata), 32'(m_rdata));

        // Back-to-back: write then read issued in the ack cycle
        pat = 5'b00000;
        @(negedge clk);
        wr_req = 1'b1; cpu_addr = 9'h003; cpu_wdata = 16'h0001;
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            pat[c-1] = ack;
            if (c == 2) rd_req = 1'b1;
            if (c == 3) rd_req = 1'b0;
        end
        m_mem[9'h003] = 16'h0001;
        m_rdata = 16'h0001;
        chk("b2b ack_pattern", 32'(pat), 32'h12);
        chk("b2b rdata", 32'(cpu_rdata), 32'h0001);

        // Asynchronous reset while in WR_COMMIT
        @(negedge clk);
        wr_req = 1'b1; cpu_addr = 9'h020; cpu_wdata = 16'h9999;
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        #1;
        chk("pre_rst ram_write", 32'(ram_write), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async ram_write", 32'(ram_write), 32'd0);
        chk("async busy", 32'(busy), 32'd0);
        chk("async ack", 32'(ack), 32'd0);
        chk("async leds", 32'(leds), 32'd0);
        chk("async rdata", 32'(cpu_rdata), 32'd0);
        m_leds = 16'h0000;
        m_rdata = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        chk("in_rst ack", 32'(ack), 32'd0);
        reset_n = 1'b1;
        model_apply(1'b1, 1'b0, 9'h005, 16'h0000, 16'h0000, lat, wcnt);
        run_req("post_rst", 1'b1, 1'b0, 9'h005, 16'h0000, 16'h0000, lat, wcnt, m_rdata, m_leds);

        // Randomized requests against the model
        for (int i = 0; i < 60; i++) begin
            rd = 1'($urandom); wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            case ($urandom_range(0, 3))
                0: a = LED_A;
                1: a = SW_A;
                2: a = 9'($urandom_range(0, 7));
                default: a = 9'($urandom);
            endcase
            d  = 16'($urandom);
            sw = 16'($urandom);
            model_apply(rd, wr, a, d, sw, lat, wcnt);
            run_req($sformatf("rand%0d", i), rd, wr, a, d, sw, lat, wcnt, m_rdata, m_leds);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Memory-bus controller between the CPU datapath and the synchronous 512x16 data RAM. It accepts single-word read/write requests from the CPU and hides the RAM's one-cycle registered read latency behind a req/ack handshake. It also decodes two memory-mapped I/O addresses: an LED output register and a switch input port.

Parameters:
DATA_WIDTH, 16, word width of CPU data, RAM data, LEDs and switches
ADDR_WIDTH, 9, word address width, shared by CPU and RAM
LED_ADDR, 9'h1FF, write-only address of the LED register
SW_ADDR, 9'h1FE, read-only address of the switch port

Ports:
clk  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
rd_req  input  1  CPU read request; sampled only in IDLE
wr_req  input  1  CPU write request; sampled only in IDLE
cpu_addr  input  ADDR_WIDTH  request address
cpu_wdata  input  DATA_WIDTH  write data
cpu_rdata  output  DATA_WIDTH  registered read data; valid while ack=1
ack  output  1  one-cycle completion pulse
busy  output  1  high whenever state is not IDLE
ram_read_address  output  ADDR_WIDTH  to RAM read_address
ram_write_address  output  ADDR_WIDTH  to RAM write_address
ram_write  output  1  to RAM write
ram_din  output  DATA_WIDTH  to RAM din
ram_dout  input  DATA_WIDTH  from RAM dout; valid one cycle after address is presented
switches  input  DATA_WIDTH  external switch inputs
leds  output  DATA_WIDTH  LED register

Behaviour:
- Reset: clk is the only clock; reset_n is asynchronous, active-low. While reset_n=0, the following hold immediately, independent of clk: state=IDLE, addr_q=0, wdata_q=0, cpu_rdata=0, ack=0, leds=0, ram_write=0, busy=0.
- States: IDLE, RD_ISSUE, RD_CAPTURE, WR_COMMIT.
- RAM-side outputs:
  - ram_read_address = ram_write_address = addr_q.
  - ram_din = wdata_q.
  - ram_write = (state==WR_COMMIT).
  - All are decoded purely from registers; no CPU input reaches the RAM combinationally.
- Request priority and capture, at a rising edge in IDLE:
  - wr_req=1 wins over rd_req; a simultaneous read is dropped, not queued.
  - On any accepted request, addr_q<=cpu_addr and wdata_q<=cpu_wdata.
- RAM read (rd_req, addr not SW_ADDR):
  - Edge E0: IDLE->RD_ISSUE.
  - Edge E1: RAM captures addr_q; RD_ISSUE->RD_CAPTURE.
  - Edge E2: cpu_rdata<=ram_dout, ack<=1, ->IDLE.
  - ack is high in the cycle following E2, so latency is 3 cycles from request edge to ack.
- RAM write (wr_req, addr not LED_ADDR):
  - Edge E0: ->WR_COMMIT; ram_write=1 for exactly one cycle.
  - Edge E1: RAM stores the word; ack<=1; ->IDLE.
  - Latency is 2 cycles.
- I/O read (rd_req, addr==SW_ADDR): at E0, cpu_rdata<=switches and ack<=1; state stays IDLE. Latency 1 cycle. The RAM is not accessed.
- I/O write (wr_req, addr==LED_ADDR): at E0, leds<=cpu_wdata and ack<=1; state stays IDLE. Latency 1 cycle; ram_write stays 0.
- Writes to SW_ADDR go to RAM; reads of LED_ADDR read RAM. The RAM words at those addresses are otherwise shadowed only in the decoded direction.
- ack: high for exactly one cycle per accepted request; ack<=0 on every other edge.
- cpu_rdata: holds its value until the next read completes; writes leave it unchanged.
- Back-to-back: state is IDLE during the ack cycle, so a new request may be accepted on the same edge that clears ack.
- Requests seen while busy=1 are ignored, not queued; the CPU must hold or re-issue them.
- Read-after-write to the same address returns the new data, because the write commits at E1 before any subsequent read issue.
- Reset mid-operation: the transaction aborts and ram_write drops asynchronously. An aborted write may or may not have reached RAM depending on whether E1 occurred; no ack is produced.
- Address wrap: none; addresses are full ADDR_WIDTH and every value is legal.

Test Plan:
1. Write RAM: wr_req, addr=9'h005, wdata=16'hABCD -> ram_write=1 for one cycle with address 5 and din ABCD; ack 2 cycles after the request edge; busy high for 1 cycle.
2. Read RAM: rd_req, addr=9'h005 (after test 1) -> ack exactly 3 cycles after the request edge with cpu_rdata=16'hABCD; busy high for 2 cycles; ram_write stays 0.
3. I/O: wr_req addr=9'h1FF, wdata=16'h00F0 -> leds=16'h00F0 and ack the next cycle, ram_write never asserted. Then switches=16'h1234, rd_req addr=9'h1FE -> cpu_rdata=16'h1234 with 1-cycle ack.
4. Priority/ignore: rd_req=wr_req=1, addr=9'h00A, wdata=16'h5555 -> write performed, read dropped. rd_req pulsed during WR_COMMIT -> ignored, exactly one ack.
5. Back-to-back: write 16'h0001 to addr 3, then a read of addr 3 issued on the ack cycle -> read accepted immediately and returns 16'h0001; total 5 cycles from first request to second ack.
6. Reset mid-op: reset_n=0 asserted asynchronously between edges while in WR_COMMIT -> ram_write=0, busy=0, ack=0, leds=0, cpu_rdata=0 immediately; after release, a read of addr 5 completes normally in 3 cycles.
